// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle main control FSM for the RISC-V core.
// Sequences fetch/decode/execute/memory/writeback from the IR opcode and
// drives datapath selects, write enables, branch request and ALUOp.
// Optional feature: define ILLEGAL_OP_HALT_EN to halt on an undefined
// opcode (sticky illegal_op until rst); otherwise it executes as a NOP.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       branch,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic       illegal_op
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LINKWB   = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
`ifdef ILLEGAL_OP_HALT_EN
    localparam logic [3:0] S_HALT     = 4'd14;
`endif

    logic [3:0] state;
    logic [3:0] state_n;

    // State register: reset returns to FETCH
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_n;
    end

    // Next-state decode; unencoded states recover to FETCH
    always_comb begin
        state_n = S_FETCH;
        case (state)
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXECR;
                    OP_I:         state_n = S_EXECI;
                    OP_BR:        state_n = S_BRANCH;
                    OP_JAL:       state_n = S_JAL;
                    OP_JALR:      state_n = S_JALR;
                    OP_LUI:       state_n = S_LUI;
`ifdef ILLEGAL_OP_HALT_EN
                    default:      state_n = S_HALT;
`else
                    default:      state_n = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_n = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_n = S_MEMWB;
            S_EXECR:    state_n = S_ALUWB;
            S_EXECI:    state_n = S_ALUWB;
            S_JAL:      state_n = S_LINKWB;
            S_JALR:     state_n = S_LINKWB;
`ifdef ILLEGAL_OP_HALT_EN
            S_HALT:     state_n = S_HALT;
`endif
            default:    state_n = S_FETCH;
        endcase
    end

    // Moore output decode; everything forced low while rst is asserted
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        branch     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUOp      = 2'b00;
        illegal_op = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (op == OP_JAL) ? 3'b100 : 3'b010;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (op == OP_SW) ? 3'b001 : 3'b000;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b01;
                    branch  = 1'b1;
                end
                S_JAL: PCWrite = 1'b1;
                S_JALR: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                end
                S_LINKWB: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    RegWrite  = 1'b1;
                end
                S_LUI: begin
                    ImmSrc    = 3'b011;
                    ResultSrc = 2'b11;
                    RegWrite  = 1'b1;
                end
`ifdef ILLEGAL_OP_HALT_EN
                S_HALT: illegal_op = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule
